// File: rtl/eth_udp_rx_mux.sv
// eth_udp_rx_mux
//   Receive path between rmii_handler and the application. Parses
//   Ethernet/IPv4/UDP, accepts NUM_PORTS consecutive UDP destination ports
//   starting at PORT_BASE and checks the FCS. Payload bytes are written
//   speculatively into a circular buffer and become visible to the reader
//   only once the frame is committed; a failed frame rewinds the write
//   pointer so nothing of it is ever output.
//
// Ports
//   clk, resetn        50 MHz RMII clock, asynchronous active-low reset
//   data_valid         CRS_DV, high for the duration of a frame
//   rx_byte(_valid)    assembled byte plus a one-cycle strobe
//   m_data/m_valid/m_ready/m_last/m_chan
//                      ready/valid payload stream tagged with channel index
//   frame_ok           pulse: matched frame committed
//   frame_drop         pulse: matched frame discarded
//   crc_err            pulse: FCS failure on any frame past the SFD
module eth_udp_rx_mux #(
  parameter logic [47:0] FPGA_MAC     = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [31:0] FPGA_IP      = 32'hC0_00_02_92,
  parameter logic [15:0] PORT_BASE    = 16'd5005,
  parameter int          NUM_PORTS    = 4,
  parameter int          BUF_DEPTH    = 2048,
  parameter int          DESC_DEPTH   = 8,
  parameter bit          ACCEPT_BCAST = 1'b1,
  localparam int         CW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          data_valid,
  input  logic [7:0]    rx_byte,
  input  logic          rx_byte_valid,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [CW-1:0] m_chan,
  output logic          frame_ok,
  output logic          frame_drop,
  output logic          crc_err
);

  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int PW  = AW + 1;
  localparam int DW  = $clog2(DESC_DEPTH);
  localparam int DPW = DW + 1;
  localparam logic [31:0]    CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [PW-1:0]  BUF_FULL    = PW'(BUF_DEPTH);
  localparam logic [DPW-1:0] DESC_FULL   = DPW'(DESC_DEPTH);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SKIP, HDR, PAYLOAD, TRAIL, FEND} state_t;

  // Reflected CRC-32 (poly 0x04C11DB7), one byte LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  state_t         state;
  logic           armed;
  logic [5:0]     hdr_cnt;
  logic           ucast_ok, bcast_ok, ignore, short_len, hdr_done, complete, ovf;
  logic [7:0]     hi_byte;
  logic [CW-1:0]  chan;
  logic [15:0]    pay_len, pay_cnt;
  logic [31:0]    crc;
  logic [PW-1:0]  wr_ptr, wr_spec, rd_ptr;
  logic [DPW-1:0] desc_wr, desc_rd;
  logic [15:0]    out_cnt;

  logic [7:0]     buf_mem   [BUF_DEPTH];
  logic [15:0]    desc_len  [DESC_DEPTH];
  logic [CW-1:0]  desc_chan [DESC_DEPTH];

  logic [7:0]  mac_exp, fix_exp;
  logic        fix_chk, mac_fail, port_bad;
  logic [15:0] word_val, port_off;
  logic        buf_full, desc_full, crc_good, matched, commit, buf_we;
  logic        desc_empty, head_last;
  logic [15:0] head_len;

  // Header field decode for the byte currently at hdr_cnt (0 = first byte after SFD).
  always_comb begin
    mac_exp = 8'h00;
    fix_exp = 8'h00;
    fix_chk = 1'b0;
    case (hdr_cnt)
      6'd0:  mac_exp = FPGA_MAC[47:40];
      6'd1:  mac_exp = FPGA_MAC[39:32];
      6'd2:  mac_exp = FPGA_MAC[31:24];
      6'd3:  mac_exp = FPGA_MAC[23:16];
      6'd4:  mac_exp = FPGA_MAC[15:8];
      6'd5:  mac_exp = FPGA_MAC[7:0];
      6'd12: begin fix_chk = 1'b1; fix_exp = 8'h08; end
      6'd13: begin fix_chk = 1'b1; fix_exp = 8'h00; end
      6'd14: begin fix_chk = 1'b1; fix_exp = 8'h45; end
      6'd23: begin fix_chk = 1'b1; fix_exp = 8'd17; end
      6'd30: begin fix_chk = 1'b1; fix_exp = FPGA_IP[31:24]; end
      6'd31: begin fix_chk = 1'b1; fix_exp = FPGA_IP[23:16]; end
      6'd32: begin fix_chk = 1'b1; fix_exp = FPGA_IP[15:8]; end
      6'd33: begin fix_chk = 1'b1; fix_exp = FPGA_IP[7:0]; end
      default: ;
    endcase
    // hi_byte holds the previous header byte, so this is the big-endian
    // 16-bit field ending at the current byte (port at 37, length at 39).
    word_val = {hi_byte, rx_byte};
    port_off = word_val - PORT_BASE;
    port_bad = (word_val < PORT_BASE) || (port_off >= 16'(NUM_PORTS));
    mac_fail = !((ucast_ok && (rx_byte == mac_exp)) ||
                 (ACCEPT_BCAST && bcast_ok && (rx_byte == 8'hFF)));
  end

  // Free space is measured against the read pointer, which already excludes
  // the byte held in the output register.
  assign buf_full  = (wr_spec - rd_ptr) == BUF_FULL;
  assign desc_full = (desc_wr - desc_rd) == DESC_FULL;
  assign crc_good  = (crc == CRC_RESIDUE);
  assign matched   = hdr_done && !ignore;
  assign commit    = (state == FEND) && matched && crc_good && complete && !ovf;
  assign buf_we    = (state == PAYLOAD) && data_valid && rx_byte_valid && !ovf && !buf_full;

  // Parser / commit FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      armed      <= 1'b0;
      hdr_cnt    <= '0;
      ucast_ok   <= 1'b0;
      bcast_ok   <= 1'b0;
      ignore     <= 1'b0;
      short_len  <= 1'b0;
      hdr_done   <= 1'b0;
      complete   <= 1'b0;
      ovf        <= 1'b0;
      hi_byte    <= '0;
      chan       <= '0;
      pay_len    <= '0;
      pay_cnt    <= '0;
      crc        <= '1;
      wr_ptr     <= '0;
      wr_spec    <= '0;
      desc_wr    <= '0;
      frame_ok   <= 1'b0;
      frame_drop <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      frame_ok   <= 1'b0;
      frame_drop <= 1'b0;
      crc_err    <= 1'b0;
      // After reset a frame already in flight is ignored: a new frame is
      // only taken once data_valid has been seen low.
      if (!data_valid) armed <= 1'b1;
      case (state)
        IDLE: if (armed && data_valid) state <= PREAMBLE;
        PREAMBLE: begin
          if (!data_valid) state <= IDLE;
          else if (rx_byte_valid) begin
            if (rx_byte == 8'hD5) begin
              state     <= HDR;
              hdr_cnt   <= '0;
              crc       <= '1;
              ucast_ok  <= 1'b1;
              bcast_ok  <= 1'b1;
              ignore    <= 1'b0;
              short_len <= 1'b0;
              hdr_done  <= 1'b0;
              complete  <= 1'b0;
              ovf       <= 1'b0;
              pay_len   <= '0;
              pay_cnt   <= '0;
            end else if (rx_byte != 8'h55) begin
              state <= SKIP;
            end
          end
        end
        SKIP: if (!data_valid) state <= IDLE;
        HDR: begin
          if (!data_valid) state <= FEND;
          else if (rx_byte_valid) begin
            crc     <= crc_byte(crc, rx_byte);
            hdr_cnt <= hdr_cnt + 6'd1;
            hi_byte <= rx_byte;
            if (hdr_cnt < 6'd6) begin
              if (rx_byte != mac_exp) ucast_ok <= 1'b0;
              if (rx_byte != 8'hFF)   bcast_ok <= 1'b0;
              if (hdr_cnt == 6'd5 && mac_fail) ignore <= 1'b1;
            end
            if (fix_chk && (rx_byte != fix_exp)) ignore <= 1'b1;
            if (hdr_cnt == 6'd37) begin
              if (port_bad) ignore <= 1'b1;
              chan <= port_off[CW-1:0];
            end
            if (hdr_cnt == 6'd39) begin
              short_len <= (word_val < 16'd8);
              pay_len   <= word_val - 16'd8;
            end
            if (hdr_cnt == 6'd41) begin
              hdr_done <= 1'b1;
              if (ignore || short_len || pay_len == 16'd0) begin
                state    <= TRAIL;
                complete <= !short_len;
              end else begin
                state <= PAYLOAD;
                if (desc_full) ovf <= 1'b1;
              end
            end
          end
        end
        PAYLOAD: begin
          if (!data_valid) state <= FEND;
          else if (rx_byte_valid) begin
            crc     <= crc_byte(crc, rx_byte);
            pay_cnt <= pay_cnt + 16'd1;
            if (!ovf) begin
              if (buf_full) ovf <= 1'b1;
              else          wr_spec <= wr_spec + PW'(1);
            end
            if (pay_cnt == pay_len - 16'd1) begin
              state    <= TRAIL;
              complete <= 1'b1;
            end
          end
        end
        TRAIL: begin
          if (!data_valid) state <= FEND;
          else if (rx_byte_valid) crc <= crc_byte(crc, rx_byte);
        end
        FEND: begin
          state   <= IDLE;
          crc_err <= !crc_good;
          if (commit) begin
            wr_ptr   <= wr_spec;
            frame_ok <= 1'b1;
            if (pay_len != 16'd0) desc_wr <= desc_wr + DPW'(1);
          end else if (matched) begin
            wr_spec    <= wr_ptr;
            frame_drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload and descriptor storage
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_spec[AW-1:0]] <= rx_byte;
    if (commit && pay_len != 16'd0) begin
      desc_len[desc_wr[DW-1:0]]  <= pay_len;
      desc_chan[desc_wr[DW-1:0]] <= chan;
    end
  end

  assign desc_empty = (desc_wr == desc_rd);
  assign head_len   = desc_len[desc_rd[DW-1:0]];
  assign head_last  = (out_cnt == head_len - 16'd1);

  // Output stage: the head descriptor stays in the FIFO until its last byte
  // has been fetched, so a stalled frame still occupies its slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      desc_rd <= '0;
      out_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_chan  <= '0;
    end else if (!m_valid || m_ready) begin
      if (!desc_empty) begin
        m_valid <= 1'b1;
        m_data  <= buf_mem[rd_ptr[AW-1:0]];
        m_chan  <= desc_chan[desc_rd[DW-1:0]];
        m_last  <= head_last;
        rd_ptr  <= rd_ptr + PW'(1);
        if (head_last) begin
          out_cnt <= '0;
          desc_rd <= desc_rd + DPW'(1);
        end else begin
          out_cnt <= out_cnt + 16'd1;
        end
      end else begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/eth_udp_rx_mux.md
Name: eth_udp_rx_mux

Overview:
- Parametrised successor to the single-port receive path: takes RMII-assembled bytes, parses Ethernet/IPv4/UDP, matches NUM_PORTS consecutive UDP destination ports, and checks the FCS.
- Payload is stored in a circular buffer and released only after the FCS passes. Bad frames are discarded entirely.
- Output is a ready/valid byte stream tagged with a channel index. It sits between rmii_handler and the application logic.

Parameters:
- FPGA_MAC, 48'h00_1A_2B_3C_4D_5E, accepted unicast destination MAC
- FPGA_IP, 32'hC0_00_02_92, accepted IPv4 destination address
- PORT_BASE, 16'd5005, UDP port for channel 0; channel i = PORT_BASE+i
- NUM_PORTS, 4, number of channels, 1..16
- BUF_DEPTH, 2048, payload buffer bytes, power of 2
- DESC_DEPTH, 8, committed-frame descriptor FIFO entries, power of 2
- ACCEPT_BCAST, 1, 1 = also accept destination MAC FF:FF:FF:FF:FF:FF

Ports:
- clk  in  1  50 MHz RMII reference clock
- resetn  in  1  asynchronous active-low reset
- data_valid  in  1  CRS_DV; high for the duration of a frame
- rx_byte  in  8  byte from rmii_handler
- rx_byte_valid  in  1  one-cycle strobe per rx_byte
- m_data  out  8  payload byte
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accepts byte when m_valid&&m_ready
- m_last  out  1  last payload byte of the frame
- m_chan  out  $clog2(NUM_PORTS) (min 1)  channel index of the current frame
- frame_ok  out  1  one-cycle pulse: matched frame committed
- frame_drop  out  1  one-cycle pulse: matched frame discarded
- crc_err  out  1  one-cycle pulse: FCS failure (any frame past SFD)

Behaviour:
- Reset: all outputs 0, pointers and FIFOs empty, parser returns to IDLE. Reset is asynchronous and may be asserted mid-frame; after release, input is ignored until data_valid has been low for at least one cycle.
- Frame end = data_valid sampled low after being high (registered falling edge).
- Parser states: IDLE -> PREAMBLE -> HDR -> PAYLOAD -> TRAIL -> FEND.
  - IDLE: waits for data_valid high.
  - PREAMBLE: discards bytes until 0xD5. Any byte other than 0x55 or 0xD5 moves to SKIP, which waits for frame end.
  - HDR: byte counter runs from the first post-SFD byte. Match checks: dst MAC (bytes 0-5, with ACCEPT_BCAST), EtherType 0x0800, IP byte0 = 0x45, protocol 17, IP dst, UDP dst port in [PORT_BASE, PORT_BASE+NUM_PORTS-1]. Any mismatch sets `ignore`; the frame is consumed silently with no pulses except crc_err.
  - PAYLOAD: UDP length L is latched; payload is L-8 bytes, written at a speculative write pointer.
  - TRAIL: padding and FCS bytes.
- CRC-32: reflected, init 0xFFFFFFFF, covers every byte after SFD including the FCS. Good frame iff the register equals 0xDEBB20E3 at frame end.
- Space check: overflow is raised if a payload write would reach the committed read pointer, or if the descriptor FIFO is full when the payload starts. Overflow stops further writes and marks the frame dropped.
- At FEND, one cycle after the falling edge:
  - Matched, CRC good, no overflow, full payload received: commit the write pointer, push {length, chan} if length > 0, pulse frame_ok.
  - Matched and otherwise: rewind the speculative pointer, pulse frame_drop.
  - L < 8 or truncation before the payload completes: drop.
  - crc_err pulses whenever the CRC fails, in the same cycle as frame_drop when the frame was matched.
- Zero-length payload (L = 8): frame_ok pulses, nothing is pushed.
- Output side:
  - Pops a descriptor, then streams its bytes from the buffer.
  - m_data/m_chan/m_last are held stable while m_valid && !m_ready.
  - m_last is asserted on byte length-1; the next frame's bytes may follow the next cycle.
  - Full throughput is 1 byte/cycle. The first byte appears no later than 3 cycles after frame_ok.
- Simultaneous commit and read of the last buffered byte is legal. Free space uses the committed read pointer.
- Pointers are $clog2(BUF_DEPTH)+1 bits to distinguish full from empty; they wrap modulo 2*BUF_DEPTH.

Test Plan:
- Valid frame, port 5005, 18-byte payload 0x00..0x11, good FCS, m_ready=1 -> frame_ok once; 18 bytes on chan 0; m_last on 0x11.
- Same frame to port 5007 with last FCS byte flipped -> crc_err and frame_drop in the same cycle; m_valid stays 0.
- Frames to 5006 then 5005, m_ready held 0 for 50 cycles then 1 -> data held stable; chan 1 payload, then chan 0 payload, in order.
- Port 6000 or wrong MAC -> no pulses, no output. Broadcast MAC with ACCEPT_BCAST=1 -> accepted.
- BUF_DEPTH=64: 60-byte frame pending unread, then a 10-byte frame -> second frame_drop, first delivered intact; 9 frames with DESC_DEPTH=8 -> 9th dropped.
- resetn pulsed low mid-payload -> outputs 0 immediately; next good frame received correctly.
